env_control_fsm_n: RTL and testbench

Parametrised next-generation environmental control FSM. It takes N_SENSORS active-high "normal" sensor inputs and debounces each one. It classifies the number of abnormal sensors into five severity states, with immediate escalation and time-qualified de-escalation. It drives N_ACT actuators through a parameter-defined sensor-to-actuator map, enforcing a minimum on-time per actuator and a forced-off mask.

---
 rtl/env_control_fsm_n_if.sv | 26 ++
 rtl/env_control_fsm_n.sv | 152 +++++++++++++++
 tb/tb_env_control_fsm_n.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/env_control_fsm_n_if.sv
// rtl/env_control_fsm_n_if.sv - sensor/actuator signal bundle for env_control_fsm_n
interface env_control_fsm_n_if #(
  parameter int N_SENSORS = 6,
  parameter int N_ACT     = 6
);
  localparam int CW = $clog2(N_SENSORS + 1);

  logic [N_SENSORS-1:0] sensor_ok;
  logic [N_SENSORS-1:0] filt_ok;
  logic [CW-1:0]        abnormal_count;
  logic [2:0]           current_state;
  logic                 alarm;
  logic [N_ACT-1:0]     act;

  // master drives raw sensors and observes the controller
  modport master (
    output sensor_ok,
    input  filt_ok, abnormal_count, current_state, alarm, act
  );

  // slave is the controller itself
  modport slave (
    input  sensor_ok,
    output filt_ok, abnormal_count, current_state, alarm, act
  );
endinterface

// File: rtl/env_control_fsm_n.sv
// rtl/env_control_fsm_n.sv - debounced multi-sensor severity FSM with min-on actuator drive
module env_control_fsm_n #(
  parameter int N_SENSORS   = 6,
  parameter int N_ACT       = 6,
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int MIN_ON      = 8,
  parameter int MULTI_TH    = 2,
  parameter int CRIT_TH     = 4,
  // default map: s0->a4, s1->a2, s2->a0, s3->a0, s4->a3, s5->a5 (bit s*N_ACT+a)
  parameter logic [N_SENSORS*N_ACT-1:0] ACT_MAP  = 36'h8_0804_1110,
  parameter logic [N_ACT-1:0]           ACT_MASK = 6'b000010
) (
  input  logic              clk,
  input  logic              reset,
  env_control_fsm_n_if.slave bus
);

  localparam int CW = $clog2(N_SENSORS + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int OW = $clog2(MIN_ON + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [OW-1:0] MIN_C     = OW'(MIN_ON);
  localparam logic [CW-1:0] MULTI_C   = CW'(MULTI_TH);
  localparam logic [CW-1:0] CRIT_C    = CW'(CRIT_TH);
  localparam logic [CW-1:0] ALL_C     = CW'(N_SENSORS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SINGLE = 3'd1;
  localparam logic [2:0] S_MULTI  = 3'd2;
  localparam logic [2:0] S_CRIT   = 3'd3;
  localparam logic [2:0] S_EMERG  = 3'd4;

  logic [N_SENSORS-1:0] filt_q;
  logic [DW-1:0]        deb_cnt [N_SENSORS];
  logic [CW-1:0]        ab_cnt;
  logic [2:0]           target;
  logic [2:0]           state_q, state_nxt;
  logic [HW-1:0]        hold_q, hold_nxt;
  logic [N_ACT-1:0]     demand;
  logic                 alarm;
  logic [N_ACT-1:0]     act_q;
  logic [OW-1:0]        on_cnt [N_ACT];

  // per-sensor debounce: flip filtered value after DEB_CYCLES consecutive mismatches
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= '1;
      for (int i = 0; i < N_SENSORS; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_SENSORS; i++) begin
        if (bus.sensor_ok[i] == filt_q[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          filt_q[i]  <= ~filt_q[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // count abnormal filtered sensors and map the count to a target severity
  always_comb begin
    ab_cnt = '0;
    for (int i = 0; i < N_SENSORS; i++) ab_cnt = ab_cnt + {{(CW-1){1'b0}}, ~filt_q[i]};
    if (ab_cnt == '0)          target = S_IDLE;
    else if (ab_cnt < MULTI_C) target = S_SINGLE;
    else if (ab_cnt < CRIT_C)  target = S_MULTI;
    else if (ab_cnt < ALL_C)   target = S_CRIT;
    else                       target = S_EMERG;
  end

  // severity state and de-escalation hold counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_nxt;
      hold_q  <= hold_nxt;
    end
  end

  // escalate at once; de-escalate only after a lower target persists HOLD_CYCLES edges
  always_comb begin
    state_nxt = state_q;
    hold_nxt  = '0;
    if (state_q > S_EMERG) begin
      state_nxt = S_IDLE;
    end else if (target > state_q) begin
      state_nxt = target;
    end else if (target < state_q) begin
      if (hold_q == HOLD_LAST) state_nxt = target;
      else                     hold_nxt  = hold_q + HW'(1);
    end
  end

  // alarm and actuator demand from the current severity and filtered sensors
  always_comb begin
    demand = '0;
    alarm  = (state_q == S_CRIT) || (state_q == S_EMERG);
    case (state_q)
      S_EMERG: demand = '1;
      S_SINGLE, S_MULTI, S_CRIT: begin
        for (int s = 0; s < N_SENSORS; s++)
          for (int a = 0; a < N_ACT; a++)
            if (!filt_q[s] && ACT_MAP[s*N_ACT + a]) demand[a] = 1'b1;
      end
      default: demand = '0;
    endcase
    demand = demand & ~ACT_MASK;
  end

  // actuator drive with a minimum on-time; masked channels never turn on
  always_ff @(posedge clk) begin
    if (reset) begin
      act_q <= '0;
      for (int a = 0; a < N_ACT; a++) on_cnt[a] <= '0;
    end else begin
      for (int a = 0; a < N_ACT; a++) begin
        if (ACT_MASK[a]) begin
          act_q[a]  <= 1'b0;
          on_cnt[a] <= '0;
        end else if (!act_q[a]) begin
          if (demand[a]) begin
            act_q[a]  <= 1'b1;
            on_cnt[a] <= OW'(1);
          end else begin
            on_cnt[a] <= '0;
          end
        end else if (on_cnt[a] < MIN_C) begin
          on_cnt[a] <= on_cnt[a] + OW'(1);
        end else begin
          act_q[a] <= demand[a];
          if (!demand[a]) on_cnt[a] <= '0;
        end
      end
    end
  end

  assign bus.filt_ok        = filt_q;
  assign bus.abnormal_count = ab_cnt;
  assign bus.current_state  = state_q;
  assign bus.alarm          = alarm;
  assign bus.act            = act_q;

endmodule

// File: tb/tb_env_control_fsm_n.sv
// tb/tb_env_control_fsm_n.sv - self-checking bench for env_control_fsm_n
module tb_env_control_fsm_n;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  env_control_fsm_n_if #(.N_SENSORS(6), .N_ACT(6)) ifa ();
  env_control_fsm_n_if #(.N_SENSORS(8), .N_ACT(4)) ifb ();

  env_control_fsm_n u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  env_control_fsm_n #(
    .N_SENSORS(8), .N_ACT(4), .DEB_CYCLES(2), .HOLD_CYCLES(5), .MIN_ON(3),
    .MULTI_TH(3), .CRIT_TH(6), .ACT_MAP(32'h1842_1421), .ACT_MASK(4'b0100)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  // reference model for the default configuration
  int         act_of_sensor [6] = '{4, 2, 0, 0, 3, 5};
  logic [5:0] mask_a = 6'b000010;
  logic [5:0] m_filt, m_act;
  int         m_run [6];
  int         m_on [6];
  int         m_state, m_hold;

  // alternate configuration: per-sensor actuator sets
  logic [3:0] map_b [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001,
                            4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] mask_b = 4'b0100;

  logic [18:0] dut_vec;
  assign dut_vec = {ifa.filt_ok, ifa.abnormal_count, ifa.current_state, ifa.alarm, ifa.act};

  function automatic int count_bad(input logic [5:0] f);
    int c = 0;
    for (int i = 0; i < 6; i++) if (!f[i]) c++;
    return c;
  endfunction

  function automatic logic [18:0] model_vec();
    int c = count_bad(m_filt);
    logic al = (m_state == 3) || (m_state == 4);
    return {m_filt, 3'(c), 3'(m_state), al, m_act};
  endfunction

  task automatic model_step(input logic [5:0] s, input logic rst);
    int c, tgt;
    logic [5:0] dem;
    if (rst) begin
      m_filt = '1; m_act = '0; m_state = 0; m_hold = 0;
      for (int i = 0; i < 6; i++) begin m_run[i] = 0; m_on[i] = 0; end
      return;
    end
    c = count_bad(m_filt);
    tgt = (c == 0) ? 0 : (c < 2) ? 1 : (c < 4) ? 2 : (c < 6) ? 3 : 4;
    dem = '0;
    if (m_state == 4) dem = '1;
    else if (m_state != 0)
      for (int i = 0; i < 6; i++) if (!m_filt[i]) dem[act_of_sensor[i]] = 1'b1;
    dem = dem & ~mask_a;
    for (int a = 0; a < 6; a++) begin
      if (!m_act[a]) begin
        if (dem[a]) begin m_act[a] = 1'b1; m_on[a] = 1; end
      end else if (m_on[a] < 8) m_on[a]++;
      else m_act[a] = dem[a];
    end
    if (tgt > m_state) begin m_state = tgt; m_hold = 0; end
    else if (tgt == m_state) m_hold = 0;
    else begin
      m_hold++;
      if (m_hold == 16) begin m_state = tgt; m_hold = 0; end
    end
    for (int i = 0; i < 6; i++) begin
      if (s[i] == m_filt[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == 4) begin m_filt[i] = ~m_filt[i]; m_run[i] = 0; end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(ifa.sensor_ok, reset);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifa.sensor_ok = 6'h3F;
    ifb.sensor_ok = 8'hFF;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (ifa.filt_ok !== 6'h3F || ifa.current_state !== 3'd0 || ifa.act !== 6'd0 || ifa.alarm !== 1'b0) begin
      errors++;
      $display("FAIL reset: filt=%h state=%0d act=%b alarm=%b, want 3f/0/000000/0",
               ifa.filt_ok, ifa.current_state, ifa.act, ifa.alarm);
    end
    reset = 1'b0;
  endtask

  task automatic test_debounce();
    ifa.sensor_ok = 6'b111110;
    for (int i = 0; i < 3; i++) tick();
    ifa.sensor_ok = 6'h3F;
    tick();
    checks++;
    if (ifa.filt_ok !== 6'h3F || ifa.current_state !== 3'd0 || ifa.act !== 6'd0) begin
      errors++;
      $display("FAIL glitch: filt=%h state=%0d act=%b, want 3f/0/000000",
               ifa.filt_ok, ifa.current_state, ifa.act);
    end
    ifa.sensor_ok = 6'b111110;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL debounce edge %0d: got %h want %h", i, dut_vec, model_vec());
      end
      if (i == 3) begin
        checks++;
        if (ifa.filt_ok !== 6'h3F) begin
          errors++;
          $display("FAIL deb_early: filt=%h want 3f", ifa.filt_ok);
        end
      end
      if (i == 4) begin
        checks++;
        if (ifa.filt_ok !== 6'b111110 || ifa.current_state !== 3'd0) begin
          errors++;
          $display("FAIL deb_flip: filt=%h state=%0d want 3e/0", ifa.filt_ok, ifa.current_state);
        end
      end
      if (i == 5) begin
        checks++;
        if (ifa.current_state !== 3'd1 || ifa.act !== 6'd0) begin
          errors++;
          $display("FAIL deb_state: state=%0d act=%b want 1/000000", ifa.current_state, ifa.act);
        end
      end
      if (i == 6) begin
        checks++;
        if (ifa.act !== 6'b010000) begin
          errors++;
          $display("FAIL deb_act: act=%b want 010000", ifa.act);
        end
      end
    end
  endtask

  task automatic test_escalation();
    ifa.sensor_ok = 6'b110000;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (ifa.current_state !== 3'd3 || ifa.alarm !== 1'b1 || ifa.act !== 6'b010101) begin
      errors++;
      $display("FAIL crit: state=%0d alarm=%b act=%b want 3/1/010101",
               ifa.current_state, ifa.alarm, ifa.act);
    end
    ifa.sensor_ok = 6'h00;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (ifa.current_state !== 3'd4 || ifa.alarm !== 1'b1 || ifa.act !== 6'b111101) begin
      errors++;
      $display("FAIL emerg: state=%0d alarm=%b act=%b want 4/1/111101",
               ifa.current_state, ifa.alarm, ifa.act);
    end
  endtask

  task automatic test_deescalation();
    ifa.sensor_ok = 6'h3F;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (ifa.filt_ok !== 6'h3F || ifa.current_state !== 3'd4) begin
      errors++;
      $display("FAIL deesc_filt: filt=%h state=%0d want 3f/4", ifa.filt_ok, ifa.current_state);
    end
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if (ifa.current_state !== 3'd4) begin
        errors++;
        $display("FAIL deesc_hold %0d: state=%0d want 4", i, ifa.current_state);
      end
    end
    tick();
    checks++;
    if (ifa.current_state !== 3'd0 || ifa.act !== 6'b111101) begin
      errors++;
      $display("FAIL deesc_drop: state=%0d act=%b want 0/111101", ifa.current_state, ifa.act);
    end
    tick();
    checks++;
    if (ifa.act !== 6'd0) begin
      errors++;
      $display("FAIL deesc_act: act=%b want 000000", ifa.act);
    end
    // re-enter emergency, then abort a de-escalation part-way through the hold
    ifa.sensor_ok = 6'h00;
    for (int i = 0; i < 6; i++) tick();
    ifa.sensor_ok = 6'h3F;
    for (int i = 0; i < 14; i++) tick();
    ifa.sensor_ok = 6'h00;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (ifa.current_state !== 3'd4 || dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL refault %0d: state=%0d vec=%h want 4 vec=%h",
                 i, ifa.current_state, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_min_on();
    int guard;
    for (int pass = 0; pass < 2; pass++) begin
      reset = 1'b1;
      ifa.sensor_ok = 6'h3F;
      tick(); tick();
      reset = 1'b0;
      ifa.sensor_ok = 6'b011111;
      guard = 0;
      while (ifa.act[5] !== 1'b1 && guard < 20) begin tick(); guard++; end
      checks++;
      if (ifa.act[5] !== 1'b1) begin
        errors++;
        $display("FAIL min_on_rise: act=%b never rose in 20 edges", ifa.act);
      end
      ifa.sensor_ok = 6'h3F;
      if (pass == 0) begin
        for (int i = 1; i <= 7; i++) begin
          tick();
          checks++;
          if (ifa.act[5] !== 1'b1 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL min_on_hold %0d: act=%b vec=%h want act5=1 vec=%h",
                     i, ifa.act, dut_vec, model_vec());
          end
        end
        tick();
        checks++;
        if (ifa.act[5] !== 1'b0) begin
          errors++;
          $display("FAIL min_on_off: act=%b want act5=0", ifa.act);
        end
      end else begin
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (ifa.act !== 6'd0 || ifa.current_state !== 3'd0 || ifa.filt_ok !== 6'h3F) begin
          errors++;
          $display("FAIL min_on_reset: act=%b state=%0d filt=%h want 000000/0/3f",
                   ifa.act, ifa.current_state, ifa.filt_ok);
        end
        reset = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] pat;
    int len, sel, cyc;
    cyc = 0;
    for (int n = 0; n < 120; n++) begin
      sel = $urandom_range(0, 5);
      pat = 6'($urandom);
      if (sel == 0) pat = 6'h3F;
      else if (sel == 1) pat = 6'h00;
      ifa.sensor_ok = pat;
      len = $urandom_range(1, 24);
      reset = ($urandom_range(0, 40) == 0);
      for (int k = 0; k < len; k++) begin
        tick();
        reset = 1'b0;
        cyc++;
        checks++;
        if (dut_vec !== model_vec()) begin
          errors++;
          $display("FAIL random cyc %0d: got %h want %h", cyc, dut_vec, model_vec());
        end
      end
    end
  endtask

  task automatic test_alt_config();
    int ks [4] = '{2, 3, 6, 8};
    int k, exp_state;
    logic [3:0] exp_act;
    reset = 1'b1;
    ifa.sensor_ok = 6'h3F;
    ifb.sensor_ok = 8'hFF;
    tick(); tick();
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      k = ks[j];
      ifb.sensor_ok = ~8'((1 << k) - 1);
      for (int i = 0; i < 6; i++) tick();
      exp_state = (k == 0) ? 0 : (k < 3) ? 1 : (k < 6) ? 2 : (k < 8) ? 3 : 4;
      exp_act = '0;
      if (exp_state == 4) exp_act = 4'b1111;
      else for (int s = 0; s < k; s++) exp_act = exp_act | map_b[s];
      exp_act = exp_act & ~mask_b;
      checks++;
      if (ifb.current_state !== 3'(exp_state) || ifb.abnormal_count !== 4'(k) ||
          ifb.act !== exp_act || ifb.alarm !== (exp_state >= 3)) begin
        errors++;
        $display("FAIL alt k=%0d: state=%0d cnt=%0d act=%b alarm=%b want %0d/%0d/%b/%b",
                 k, ifb.current_state, ifb.abnormal_count, ifb.act, ifb.alarm,
                 exp_state, k, exp_act, exp_state >= 3);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ifa.sensor_ok = 6'h3F;
    ifb.sensor_ok = 8'hFF;
    test_reset();
    test_debounce();
    test_escalation();
    test_deescalation();
    test_min_on();
    test_random();
    test_alt_config();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
